// File: rtl/pulse_gen_mc.sv
// pulse_gen_mc: multi-channel programmable pulse-train generator (delay, width, period, burst count).
// Define PULSE_GEN_SYNC_START_EN to add a sync_start input that launches all armed idle channels together.
module pulse_gen_mc #(
  parameter int   N_CH = 4,
  parameter int   W    = 16,
  parameter logic B0   = 1'b0,
  localparam int  CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [CW-1:0]   cfg_ch,
  input  logic [1:0]      cfg_addr,
  input  logic [W-1:0]    cfg_data,
  output logic            cfg_err,
  input  logic [N_CH-1:0] start,
  input  logic [N_CH-1:0] stop,
`ifdef PULSE_GEN_SYNC_START_EN
  input  logic            sync_start,
`endif
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] outb,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DLY   = 2'd1;
  localparam logic [1:0] S_ACT   = 2'd2;
  localparam logic [1:0] S_INACT = 2'd3;

  localparam logic [1:0] A_DELAY  = 2'd0;
  localparam logic [1:0] A_WIDTH  = 2'd1;
  localparam logic [1:0] A_PERIOD = 2'd2;

  logic [1:0]      state   [N_CH];
  logic [W-1:0]    delay_r [N_CH];
  logic [W-1:0]    width_r [N_CH];
  logic [W-1:0]    period_r[N_CH];
  logic [W-1:0]    count_r [N_CH];
  // Working copies taken at start so a burst never sees later register writes.
  logic [W-1:0]    width_s [N_CH];
  logic [W-1:0]    gap_s   [N_CH];
  logic [W-1:0]    count_s [N_CH];
  logic [W-1:0]    cnt     [N_CH];
  logic [W-1:0]    pcnt    [N_CH];

  logic [N_CH-1:0] out_q;
  logic [N_CH-1:0] done_q;
  logic [N_CH-1:0] wr_hit;
  logic [N_CH-1:0] wr_rej;
  logic [N_CH-1:0] go_req;
  logic [N_CH-1:0] start_ok;
  logic [N_CH-1:0] start_rej;
  logic [N_CH-1:0] is_last;
  logic            err_d;
`ifdef PULSE_GEN_SYNC_START_EN
  logic [N_CH-1:0] arm;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    wr_hit    = '0;
    wr_rej    = '0;
    go_req    = '0;
    start_ok  = '0;
    start_rej = '0;
    is_last   = '0;
    busy      = '0;
    for (int c = 0; c < N_CH; c++) begin
      busy[c]   = (state[c] != S_IDLE);
      wr_hit[c] = cfg_we && (cfg_ch == CW'(c));
      wr_rej[c] = wr_hit[c] && busy[c];
`ifdef PULSE_GEN_SYNC_START_EN
      go_req[c] = !busy[c] && (start[c] || (sync_start && arm[c])) && !stop[c];
`else
      go_req[c] = !busy[c] && start[c] && !stop[c];
`endif
      start_ok[c]  = go_req[c] && (width_r[c] != '0) && (period_r[c] > width_r[c]);
      start_rej[c] = go_req[c] && !start_ok[c];
      // Final pulse of a finite burst: its trailing idle cycle is spent back in IDLE.
      is_last[c]   = (count_s[c] != '0) && (pcnt[c] == count_s[c]);
    end
    err_d = (|wr_rej) | (|start_rej);
  end

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every channel reacts to pre-edge values.
    if (rst) begin
      cfg_err <= 1'b0;
      out_q   <= {N_CH{B0}};
      done_q  <= '0;
`ifdef PULSE_GEN_SYNC_START_EN
      arm     <= '0;
`endif
      for (int c = 0; c < N_CH; c++) begin
        state[c]    <= S_IDLE;
        delay_r[c]  <= '0;
        width_r[c]  <= W'(1);
        period_r[c] <= W'(2);
        count_r[c]  <= '0;
        width_s[c]  <= '0;
        gap_s[c]    <= '0;
        count_s[c]  <= '0;
        cnt[c]      <= '0;
        pcnt[c]     <= '0;
      end
    end else begin
      cfg_err <= err_d;
      for (int c = 0; c < N_CH; c++) begin
        done_q[c] <= 1'b0;
`ifdef PULSE_GEN_SYNC_START_EN
        if (sync_start && !busy[c]) arm[c] <= 1'b0;
`endif
        if (wr_hit[c] && !busy[c]) begin
          case (cfg_addr)
            A_DELAY:  delay_r[c]  <= cfg_data;
            A_WIDTH:  width_r[c]  <= cfg_data;
            A_PERIOD: period_r[c] <= cfg_data;
            default: begin
`ifdef PULSE_GEN_SYNC_START_EN
              count_r[c] <= {1'b0, cfg_data[W-2:0]};
              arm[c]     <= cfg_data[W-1];
`else
              count_r[c] <= cfg_data;
`endif
            end
          endcase
        end

        if (stop[c]) begin
          state[c] <= S_IDLE;
          out_q[c] <= B0;
        end else begin
          case (state[c])
            S_IDLE: begin
              if (start_ok[c]) begin
                state[c]   <= S_DLY;
                cnt[c]     <= delay_r[c];
                width_s[c] <= width_r[c];
                gap_s[c]   <= period_r[c] - width_r[c];
                count_s[c] <= count_r[c];
                pcnt[c]    <= '0;
              end
            end
            S_DLY: begin
              if (cnt[c] == '0) begin
                state[c] <= S_ACT;
                out_q[c] <= ~B0;
                cnt[c]   <= width_s[c] - W'(1);
                if (pcnt[c] != '1) pcnt[c] <= pcnt[c] + W'(1);
              end else begin
                cnt[c] <= cnt[c] - W'(1);
              end
            end
            S_ACT: begin
              if (cnt[c] == '0) begin
                out_q[c] <= B0;
                if (is_last[c] && (gap_s[c] == W'(1))) begin
                  state[c]  <= S_IDLE;
                  done_q[c] <= 1'b1;
                end else begin
                  state[c] <= S_INACT;
                  cnt[c]   <= is_last[c] ? gap_s[c] - W'(2) : gap_s[c] - W'(1);
                end
              end else begin
                cnt[c] <= cnt[c] - W'(1);
              end
            end
            default: begin
              if (cnt[c] == '0) begin
                if (is_last[c]) begin
                  state[c]  <= S_IDLE;
                  done_q[c] <= 1'b1;
                end else begin
                  state[c] <= S_ACT;
                  out_q[c] <= ~B0;
                  cnt[c]   <= width_s[c] - W'(1);
                  if (pcnt[c] != '1) pcnt[c] <= pcnt[c] + W'(1);
                end
              end else begin
                cnt[c] <= cnt[c] - W'(1);
              end
            end
          endcase
        end
      end
    end
  end

  assign out  = out_q;
  assign outb = ~out_q;
  assign done = done_q;

endmodule

// File: tb/tb_pulse_gen_mc.sv
// tb_pulse_gen_mc: directed self-checking bench for pulse_gen_mc (default build, 4 channels, W=16, B0=0).
module tb_pulse_gen_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_err;
  logic [3:0]  start;
  logic [3:0]  stop;
  logic        sync_start;
  logic [3:0]  out;
  logic [3:0]  outb;
  logic [3:0]  busy;
  logic [3:0]  done;

  int n_cmp = 0;
  int n_bad = 0;

  pulse_gen_mc #(.N_CH(4), .W(16), .B0(1'b0)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_err  (cfg_err),
    .start    (start),
    .stop     (stop),
`ifdef PULSE_GEN_SYNC_START_EN
    .sync_start (sync_start),
`endif
    .out      (out),
    .outb     (outb),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input int ch, input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_addr = 2'(addr);
    cfg_data = 16'(data);
    tick();
    cfg_we   = 1'b0;
  endtask

  // Expected {out, busy, done} i edges after the start edge; the last idle cycle of a finite burst is IDLE.
  function automatic logic [2:0] model(input int i, input int dly, input int wid, input int per, input int cnt);
    int   t;
    logic o, b, d;
    t = i - dly - 1;
    b = (cnt == 0) || (i < dly + cnt * per);
    d = (cnt != 0) && (i == dly + cnt * per);
    o = (t >= 0) && ((t % per) < wid) && ((cnt == 0) || ((t / per) < cnt));
    return {o, b, d};
  endfunction

  task automatic watch(input int ch, input int i0, input int n,
                       input int dly, input int wid, input int per, input int cnt);
    logic [2:0] m;
    for (int i = i0; i <= n; i++) begin
      m = model(i, dly, wid, per, cnt);
      check($sformatf("ch%0d t%0d", ch, i),
            {28'd0, out[ch], outb[ch], busy[ch], done[ch]},
            {28'd0, m[2], ~m[2], m[1], m[0]});
      if (i < n) tick();
    end
  endtask

  initial begin
    logic [2:0] m;
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_data = '0;
    start = '0; stop = '0; sync_start = 1'b0;
    tick();
    tick();
    check("reset", {19'd0, out, busy, done, cfg_err}, 32'd0);
    rst = 1'b0;
    tick();

    // Finite burst: D=3 W=2 P=5 C=2 on ch0
    wr(0, 0, 3); wr(0, 1, 2); wr(0, 2, 5); wr(0, 3, 2);
    check("idle wr err", {31'd0, cfg_err}, 32'd0);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    watch(0, 0, 15, 3, 2, 5, 2);

    // Continuous square wave on ch1, then stop mid-ACT
    wr(1, 0, 0); wr(1, 1, 1); wr(1, 2, 2); wr(1, 3, 0);
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    watch(1, 0, 7, 0, 1, 2, 0);
    stop[1] = 1'b1; tick(); stop[1] = 1'b0;
    check("stop ch1", {29'd0, out[1], busy[1], done[1]}, 32'd0);
    tick();
    check("stop no done", {29'd0, out[1], busy[1], done[1]}, 32'd0);

    // Invalid config WIDTH=PERIOD on ch2
    wr(2, 1, 4); wr(2, 2, 4);
    check("ch2 wr err", {31'd0, cfg_err}, 32'd0);
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    check("bad start err", {31'd0, cfg_err}, 32'd1);
    check("bad start idle", {30'd0, out[2], busy[2]}, 32'd0);
    tick();
    check("err one cycle", {31'd0, cfg_err}, 32'd0);
    stop[2] = 1'b1; tick(); stop[2] = 1'b0;
    check("stop idle", {29'd0, out[2], busy[2], cfg_err}, 32'd0);

    // Write to busy ch0 is rejected and the running period stays 5
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    watch(0, 0, 0, 3, 2, 5, 2);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addr = 2'd2; cfg_data = 16'd9;
    tick();
    cfg_we = 1'b0;
    check("busy wr err", {31'd0, cfg_err}, 32'd1);
    watch(0, 1, 15, 3, 2, 5, 2);
    check("busy wr err clr", {31'd0, cfg_err}, 32'd0);
    wr(0, 2, 9);
    check("p9 wr err", {31'd0, cfg_err}, 32'd0);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    watch(0, 0, 22, 3, 2, 9, 2);

    // Finite burst with one-cycle gap: ACT of last pulse goes straight to IDLE
    wr(3, 0, 0); wr(3, 1, 1); wr(3, 2, 2); wr(3, 3, 3);
    start[3] = 1'b1; tick(); start[3] = 1'b0;
    watch(3, 0, 8, 0, 1, 2, 3);

    // start and stop together: stop wins
    start[3] = 1'b1; stop[3] = 1'b1; tick(); start[3] = 1'b0; stop[3] = 1'b0;
    check("start+stop", {29'd0, out[3], busy[3], cfg_err}, 32'd0);
    tick();
    check("start+stop idle", {31'd0, busy[3]}, 32'd0);

    // Phase-aligned start on all channels
    for (int c = 0; c < 4; c++) begin
      wr(c, 0, 1); wr(c, 1, 2); wr(c, 2, 3); wr(c, 3, 2);
    end
    start = 4'hF; tick(); start = 4'h0;
    for (int i = 0; i <= 8; i++) begin
      m = model(i, 1, 2, 3, 2);
      check($sformatf("align t%0d", i), {20'd0, out, busy, done},
            {20'd0, {4{m[2]}}, {4{m[1]}}, {4{m[0]}}});
      if (i < 8) tick();
    end

    // Reset mid-burst, then defaults D=0 W=1 P=2 C=0
    for (int c = 0; c < 4; c++) wr(c, 3, 0);
    start = 4'hF; tick(); start = 4'h0;
    tick(); tick(); tick();
    check("pre-rst busy", {28'd0, busy}, 32'hF);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst mid", {19'd0, out, busy, done, cfg_err}, 32'd0);
    start = 4'hF; tick(); start = 4'h0;
    check("dflt start err", {31'd0, cfg_err}, 32'd0);
    watch(0, 0, 6, 0, 1, 2, 0);
    check("dflt all", {24'd0, out, busy}, {24'd0, 4'h0, 4'hF});
    stop = 4'hF; tick(); stop = 4'h0;
    check("final stop", {24'd0, busy, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
